fifo_wptr_ctrl: RTL and testbench
=================================

# fifo_wptr_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory and drives its write address, write enable and full flag. It synchronises the Gray-coded read pointer into the write clock domain and derives full, almost-full, fill level and a sticky overflow error from it. It also exports the Gray write pointer to the read-domain controller.

## Interface
- `ADDRSIZE`, default 4: memory address bits; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AFULL_THRESH`, default 12: `walmost_full` asserts when fill level ≥ this value; legal range 1..2^ADDRSIZE.
- `SYNC_STAGES`, default 2: flop stages in the read-pointer synchroniser; minimum 2.
- `wclk` in 1: write clock. Single clock; all logic is on the rising edge.
- `wrst` in 1: reset, asynchronous, active-high.
- `winc` in 1: write request; data is presented to memory in the same cycle.
- `rptr` in ADDRSIZE+1: Gray read pointer from the read domain. Asynchronous; used only after synchronisation.
- `waddr` out ADDRSIZE: memory write address = `wbin[ADDRSIZE-1:0]`.
- `wclken` out 1: memory write enable = `winc & ~wfull`.
- `wptr` out ADDRSIZE+1: registered Gray write pointer, sent to the read domain.
- `wfull` out 1: registered full flag.
- `walmost_full` out 1: registered almost-full flag.
- `wlevel` out ADDRSIZE+1: registered fill level, 0..2^ADDRSIZE.
- `woverflow` out 1: sticky flag set by a write attempted while full.

## Operation
- Accepted write is `winc & ~wfull`. Rejected writes leave the pointers unchanged.
- `wbin_next = wbin + accepted`, computed modulo 2^(ADDRSIZE+1).
- `wgray_next = (wbin_next >> 1) ^ wbin_next`. Both `wbin` and `wptr` are registered.
- `rq` is the synchronised `rptr`. `rbin` is the Gray-to-binary conversion of `rq`, computed combinationally.
- Full condition, registered into `wfull`: `wgray_next == {~rq[A:A-1], rq[A-2:0]}`, where A = ADDRSIZE.
- Level, registered into `wlevel`: `wlevel_next = (wbin_next - rbin) mod 2^(A+1)`. The level is pessimistic: it never under-reports, because `rq` lags the true read pointer.
- Almost-full, registered into `walmost_full`: `walmost_full_next = (wlevel_next >= AFULL_THRESH)`.
- Overflow: `winc & wfull` sets `woverflow`. It stays set until `wrst`.
- Reset: `wbin`, `wptr`, `waddr`, `wlevel` and all synchroniser flops are 0. `wfull`, `walmost_full` and `woverflow` are 0.
- Wrap-around: pointers roll over from 2^(A+1)-1 to 0. The MSB distinguishes full from empty.
- Reset mid-operation: all state clears immediately (asynchronous), regardless of `winc`. The read domain must be reset in the same window.

## Timing
- `wclken` is combinational from `winc`/`wfull`, valid in the same cycle. The memory captures data on the same `wclk` edge.
- After an accepted write at edge k:
  - `waddr`, `wptr`, `wlevel`, `wfull` and `walmost_full` update at edge k.
  - `wfull` therefore blocks the very next cycle when the FIFO becomes full.
- A change on `rptr` is reflected in `rq` after SYNC_STAGES edges. It is reflected in `wfull`/`wlevel`/`walmost_full` one edge later, i.e. SYNC_STAGES+1 edges.
- `winc` held high while full sets `woverflow` on the next edge. The pointers do not move.

## Configuration
- Macro `FIFO_WOVERFLOW_EN`.
- Defined: the overflow detection register is built and `woverflow` behaves as above.
- Undefined: no register; `woverflow` is tied to 0.
- The port exists in both builds.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterised on width.
  - the pointer-width convention `PTRW = ADDRSIZE+1`.
  - the full-compare helper, so that the read-side controller reuses it.
- One sub-module: `fifo_sync_r2w`.
  - SYNC_STAGES-deep synchroniser of ADDRSIZE+1 bits, reset to 0 by `wrst`.
  - Kept separate for CDC constraints and lint waivers.

## Test plan
- Reset: assert `wrst` mid-cycle → all outputs 0 immediately; after release, `wlevel`=0 and `wfull`=0.
- Fill, with `rptr`=0 and defaults: 12 writes → `walmost_full`=1 with `wlevel`=12. After the 16th write, `wfull`=1, `wlevel`=16, `wptr`=5'b11000.
- Overflow: full, then `winc`=1 for 2 cycles → `wclken`=0, `waddr` stays 0, `woverflow`=1 and remains 1. With the macro undefined, `woverflow` stays 0.
- Drain: full, then drive `rptr`=Gray(1)=5'b00001 → `wfull` deasserts and `wlevel`=15 exactly 3 edges later; one write then re-asserts `wfull`.
- Wrap: 40 writes with `rptr` tracking (write pointer minus 3, Gray coded) → `wfull` never asserts, `waddr` cycles 0..15, `wptr` wraps through 5'b10000.
- Simultaneous: accepted write on the same edge the synchronised read pointer advances → `wlevel` unchanged, `wfull` stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers (write and read side).
// Gray/binary conversion, pointer-width convention and the full-compare helper.
// Helpers work on zero-extended PTR_MAXW-bit values so any pointer width up to 32 fits.
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend into this width.
  localparam int PTR_MAXW     = 32;
  localparam int DEF_ADDRSIZE = 4;

  // Pointers carry one extra bit over the address to tell full from empty.
  function automatic int ptrw(input int addrsize);
    return addrsize + 1;
  endfunction

  localparam int PTRW = ptrw(DEF_ADDRSIZE);

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; zero upper
  // bits make this independent of the actual pointer width.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b = '0;
    for (int i = 0; i < PTR_MAXW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Full when the next Gray write pointer equals the other pointer with its
  // two MSBs inverted (one lap ahead). width is the real pointer width.
  function automatic logic full_match(input logic [PTR_MAXW-1:0] gray_next,
                                      input logic [PTR_MAXW-1:0] gray_other,
                                      input int                  width);
    logic [PTR_MAXW-1:0] top2;
    top2 = PTR_MAXW'(3) << (width - 2);
    return gray_next == (gray_other ^ top2);
  endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Read-pointer synchroniser into the write clock domain.
// Latency: SYNC_STAGES wclk edges from rptr to rq.
// No backpressure; free-running shift register, cleared asynchronously by wrst.
module fifo_sync_r2w #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-1:0] rq
);

  // Stage 0 is the metastability-capturing flop; later stages resolve it.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the asynchronous Gray pointer through the synchroniser chain.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO (wfull, walmost_full, wlevel, woverflow).
// Latency: wclken combinational; pointers/flags registered at the write edge; rptr seen after SYNC_STAGES+1 edges.
// Backpressure: wfull masks wclken; writes while full are dropped (sticky woverflow when FIFO_WOVERFLOW_EN is defined).
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ptrw(ADDRSIZE);
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic          accepted;

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wgray_q,  wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          wafull_q, wafull_d;

  fifo_sync_r2w #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .wclk (wclk),
    .wrst (wrst),
    .rptr (rptr),
    .rq   (rq)
  );

  // Next pointer and flag values from the accepted write and the synchronised read pointer.
  always_comb begin
    accepted = winc & ~wfull_q;
    rbin     = PW'(gray2bin(PTR_MAXW'(rq)));
    wbin_d   = wbin_q + PW'(accepted);
    wgray_d  = PW'(bin2gray(PTR_MAXW'(wbin_d)));
    wfull_d  = full_match(PTR_MAXW'(wgray_d), PTR_MAXW'(rq), PW);
    // rq lags the true read pointer, so this level can only over-report.
    wlevel_d = wbin_d - rbin;
    wafull_d = (wlevel_d >= AFULL_T);
  end

  // Pointer and flag registers.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

`ifdef FIFO_WOVERFLOW_EN
  logic woverflow_q, woverflow_d;

  // Sticky overflow: any write attempted while full sets it until reset.
  always_comb begin
    woverflow_d = woverflow_q | (winc & wfull_q);
  end

  // Overflow flag register.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow_q <= 1'b0;
    end else begin
      woverflow_q <= woverflow_d;
    end
  end

  assign woverflow = woverflow_q;
`else
  assign woverflow = 1'b0;
`endif

  assign wclken       = accepted;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Bench for fifo_wptr_ctrl with default parameters (depth 16, threshold 12, 2 sync stages).
// Fixed vector table for fill/overflow/drain, then hand sequences and random traffic vs. a count-based model.
// Inputs driven on the falling edge, outputs checked on the falling edge after each rising edge.
module tb_fifo_wptr_ctrl;

`ifdef FIFO_WOVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  localparam int SYNC = 2;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] rptr;
  logic [3:0] waddr;
  logic       wclken;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int vecs = 0;
  int miscmp = 0;

  fifo_wptr_ctrl dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit       w;
    bit [4:0] rp;
    bit       clken;
    bit       full;
    bit       af;
    bit [4:0] level;
    bit [3:0] addr;
    bit [4:0] ptr;
    bit       ovf;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: plain write/read counts; read count seen by the flags lags SYNC edges.
  int wr_cnt, rd_cnt, m_level;
  bit m_full, m_af, m_ovf;
  int hist[$];

  task automatic model_reset();
    wr_cnt = 0; rd_cnt = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
  endtask

  task automatic step(input bit w, input int rd);
    rd_cnt = rd;
    winc = w;
    rptr = g5(rd);
    #1;
    chk("wclken", int'(wclken), int'(w & ~m_full));
    @(posedge wclk);
    hist.push_back(rd_cnt);
    if (w && m_full) m_ovf = m_ovf | OVF;
    else if (w) wr_cnt++;
    m_level = wr_cnt - hist[hist.size() - 1 - SYNC];
    m_full  = (m_level == 16);
    m_af    = (m_level >= 12);
    @(negedge wclk);
    chk("wfull", int'(wfull), int'(m_full));
    chk("walmost_full", int'(walmost_full), int'(m_af));
    chk("wlevel", int'(wlevel), m_level);
    chk("waddr", int'(waddr), wr_cnt % 16);
    chk("wptr", int'(wptr), int'(g5(wr_cnt)));
    chk("woverflow", int'(woverflow), int'(m_ovf));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wfull"}, int'(wfull), 0);
    chk({nm, "_walmost_full"}, int'(walmost_full), 0);
    chk({nm, "_wlevel"}, int'(wlevel), 0);
    chk({nm, "_waddr"}, int'(waddr), 0);
    chk({nm, "_wptr"}, int'(wptr), 0);
    chk({nm, "_woverflow"}, int'(woverflow), 0);
  endtask

  initial begin
    bit saw_wrap, saw_full;
    int lvl_before;

    //            w  rp        clk full af level  addr   ptr       ovf
    tbl[0]  = '{1, 5'b00000, 1, 0, 0, 5'd1,  4'd1,  5'b00001, 0};
    tbl[1]  = '{1, 5'b00000, 1, 0, 0, 5'd2,  4'd2,  5'b00011, 0};
    tbl[2]  = '{1, 5'b00000, 1, 0, 0, 5'd3,  4'd3,  5'b00010, 0};
    tbl[3]  = '{1, 5'b00000, 1, 0, 0, 5'd4,  4'd4,  5'b00110, 0};
    tbl[4]  = '{1, 5'b00000, 1, 0, 0, 5'd5,  4'd5,  5'b00111, 0};
    tbl[5]  = '{1, 5'b00000, 1, 0, 0, 5'd6,  4'd6,  5'b00101, 0};
    tbl[6]  = '{1, 5'b00000, 1, 0, 0, 5'd7,  4'd7,  5'b00100, 0};
    tbl[7]  = '{1, 5'b00000, 1, 0, 0, 5'd8,  4'd8,  5'b01100, 0};
    tbl[8]  = '{1, 5'b00000, 1, 0, 0, 5'd9,  4'd9,  5'b01101, 0};
    tbl[9]  = '{1, 5'b00000, 1, 0, 0, 5'd10, 4'd10, 5'b01111, 0};
    tbl[10] = '{1, 5'b00000, 1, 0, 0, 5'd11, 4'd11, 5'b01110, 0};
    tbl[11] = '{1, 5'b00000, 1, 0, 1, 5'd12, 4'd12, 5'b01010, 0};
    tbl[12] = '{1, 5'b00000, 1, 0, 1, 5'd13, 4'd13, 5'b01011, 0};
    tbl[13] = '{1, 5'b00000, 1, 0, 1, 5'd14, 4'd14, 5'b01001, 0};
    tbl[14] = '{1, 5'b00000, 1, 0, 1, 5'd15, 4'd15, 5'b01000, 0};
    tbl[15] = '{1, 5'b00000, 1, 1, 1, 5'd16, 4'd0,  5'b11000, 0};
    // Two writes while full: dropped, overflow set
    tbl[16] = '{1, 5'b00000, 0, 1, 1, 5'd16, 4'd0,  5'b11000, OVF};
    tbl[17] = '{1, 5'b00000, 0, 1, 1, 5'd16, 4'd0,  5'b11000, OVF};
    // Read pointer advances to Gray(1): flags follow on the third edge
    tbl[18] = '{0, 5'b00001, 0, 1, 1, 5'd16, 4'd0,  5'b11000, OVF};
    tbl[19] = '{0, 5'b00001, 0, 1, 1, 5'd16, 4'd0,  5'b11000, OVF};
    tbl[20] = '{0, 5'b00001, 0, 0, 1, 5'd15, 4'd0,  5'b11000, OVF};
    // One more write fills again
    tbl[21] = '{1, 5'b00001, 1, 1, 1, 5'd16, 4'd1,  5'b11001, OVF};

    winc = 1'b0;
    rptr = '0;
    wrst = 1'b1;
    #1;
    chk_zero("reset");
    chk("reset_wclken", int'(wclken), 0);
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    chk_zero("post_reset");

    // Table-driven fill / overflow / drain
    for (int i = 0; i < 22; i++) begin
      winc = tbl[i].w;
      rptr = tbl[i].rp;
      #1;
      chk($sformatf("t%0d_wclken", i), int'(wclken), int'(tbl[i].clken));
      @(posedge wclk);
      @(negedge wclk);
      chk($sformatf("t%0d_wfull", i), int'(wfull), int'(tbl[i].full));
      chk($sformatf("t%0d_afull", i), int'(walmost_full), int'(tbl[i].af));
      chk($sformatf("t%0d_wlevel", i), int'(wlevel), int'(tbl[i].level));
      chk($sformatf("t%0d_waddr", i), int'(waddr), int'(tbl[i].addr));
      chk($sformatf("t%0d_wptr", i), int'(wptr), int'(tbl[i].ptr));
      chk($sformatf("t%0d_woverflow", i), int'(woverflow), int'(tbl[i].ovf));
    end

    // Reset asserted mid-cycle with winc high: outputs clear without a clock edge
    winc = 1'b1;
    #2;
    wrst = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge wclk);
    winc = 1'b0;
    rptr = '0;
    @(negedge wclk);
    wrst = 1'b0;
    model_reset();
    chk_zero("midreset_release");

    // Wrap: 40 writes with the read side trailing by three entries
    saw_wrap = 0;
    saw_full = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (wr_cnt >= 3) ? wr_cnt - 3 : 0);
      if (wptr == 5'b10000) saw_wrap = 1;
      if (wfull) saw_full = 1;
    end
    chk("wrap_wptr_10000_seen", int'(saw_wrap), 1);
    chk("wrap_never_full", int'(saw_full), 0);
    chk("wrap_total_writes", wr_cnt, 40);

    // Simultaneous: write lands on the edge where the synchronised read pointer advances
    repeat (3) step(1'b0, rd_cnt);
    lvl_before = m_level;
    step(1'b0, rd_cnt + 1);
    step(1'b0, rd_cnt);
    step(1'b1, rd_cnt);
    chk("simul_wlevel_unchanged", int'(wlevel), lvl_before);
    chk("simul_wfull_low", int'(wfull), 0);

    // Random traffic: write-heavy phase then read-heavy phase
    for (int i = 0; i < 600; i++) begin
      bit w;
      int rd;
      int wp = (i < 300) ? 75 : 30;
      int rp = (i < 300) ? 30 : 75;
      w  = ($urandom_range(0, 99) < wp);
      rd = rd_cnt;
      if (rd < wr_cnt && $urandom_range(0, 99) < rp) rd = rd + 1;
      step(w, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
